// File: rtl/spi_reg_slave_pkg.sv
// Shared types and constants for the SPI register-bank responder.
//   state_t    : transaction FSM states
//   HDR_RW_BIT : header bit selecting read (1) or write (0)
//   DEF_*      : default address/data widths
package spi_pkg;

  localparam int unsigned DEF_ADDR_W = 7;
  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned HDR_RW_BIT = 7;
  // Bit counter covers one 8-bit phase (header or data).
  localparam int unsigned BIT_CNT_W  = 3;

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    DATA,
    DONE
  } state_t;

endpackage

// File: rtl/spi_reg_slave_if.sv
// Bus bundle for spi_reg_slave: SPI pins plus the local parallel register port.
//   slave  modport : the responder (drives miso, loc_rdata, strobes, status)
//   master modport : the SPI master / local logic side
interface spi_reg_slave_if
  import spi_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
);

  logic              sclk;
  logic              cs_n;
  logic              mosi;
  logic              miso;
  logic              loc_we;
  logic [ADDR_W-1:0] loc_addr;
  logic [DATA_W-1:0] loc_wdata;
  logic [DATA_W-1:0] loc_rdata;
  logic              wr_strobe;
  logic              rd_strobe;
  logic [ADDR_W-1:0] spi_addr;
  logic [DATA_W-1:0] spi_wdata;
  logic              abort;
  logic              loc_collision;

  modport slave (
    input  sclk, cs_n, mosi, loc_we, loc_addr, loc_wdata,
    output miso, loc_rdata, wr_strobe, rd_strobe, spi_addr, spi_wdata, abort, loc_collision
  );

  modport master (
    output sclk, cs_n, mosi, loc_we, loc_addr, loc_wdata,
    input  miso, loc_rdata, wr_strobe, rd_strobe, spi_addr, spi_wdata, abort, loc_collision
  );

endinterface

// File: rtl/spi_reg_slave_sync_edge.sv
// Two-flop synchronizer with registered rise/fall pulses.
//   clk, reset : system clock, async active-low reset
//   pin        : asynchronous input
//   sync       : synchronized level (2 clk latency)
//   rise, fall : one-cycle edge pulses (3 clk after the pin edge)
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic meta_q, sync_q, prev_q, rise_q, fall_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
      prev_q <= RST_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      meta_q <= pin;
      sync_q <= meta_q;
      prev_q <= sync_q;
      rise_q <= sync_q & ~prev_q;
      fall_q <= ~sync_q & prev_q;
    end
  end

  assign sync = sync_q;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/spi_reg_slave.sv
// SPI mode-0 register-bank responder, oversampled on mclk.
// Header byte = {rd_wr, addr[6:0]}, followed by one data byte, both MSB-first.
//   mclk, reset : system clock, async active-low reset
//   bus (slave) : SPI pins, local register port, strobes and status pulses
module spi_reg_slave
  import spi_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic           mclk,
  input  logic           reset,
  spi_reg_slave_if.slave bus
);

  localparam int unsigned HDR_W = ADDR_W + 1;
  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [BIT_CNT_W-1:0] CNT_LAST = '1;

  logic sclk_s, sclk_rise, sclk_fall;
  logic cs_n_s, cs_rise, cs_fall;
  logic mosi_s, mosi_rise, mosi_fall;

  spi_sync_edge #(.RST_VAL(1'b0)) u_sync_sclk (
    .clk(mclk), .reset(reset), .pin(bus.sclk), .sync(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
  );
  spi_sync_edge #(.RST_VAL(1'b1)) u_sync_cs_n (
    .clk(mclk), .reset(reset), .pin(bus.cs_n), .sync(cs_n_s), .rise(cs_rise), .fall(cs_fall)
  );
  spi_sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
    .clk(mclk), .reset(reset), .pin(bus.mosi), .sync(mosi_s), .rise(mosi_rise), .fall(mosi_fall)
  );

  logic unused_edges;
  assign unused_edges = ^{sclk_s, cs_rise, cs_fall, mosi_rise, mosi_fall};

  state_t                 state_q, state_d;
  logic [BIT_CNT_W-1:0]   cnt_q, cnt_d;
  logic [HDR_W-1:0]       hdr_q, hdr_d, hdr_next;
  logic                   rw_q, rw_d;
  logic [DATA_W-1:0]      sin_q, sin_d, sin_next;
  logic [DATA_W-1:0]      sout_q, sout_d;
  logic                   first_q, first_d;
  logic                   miso_q, miso_d;
  logic [ADDR_W-1:0]      spi_addr_q, spi_addr_d;
  logic [DATA_W-1:0]      spi_wdata_q, spi_wdata_d;
  logic                   wr_strobe_q, wr_strobe_d;
  logic                   rd_strobe_q, rd_strobe_d;
  logic                   abort_q, abort_d;
  logic                   commit;
  logic                   coll_q;
  logic [DATA_W-1:0]      loc_rdata_q;
  logic [DATA_W-1:0]      regs_q [DEPTH];

  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      hdr_q       <= '0;
      rw_q        <= 1'b0;
      sin_q       <= '0;
      sout_q      <= '0;
      first_q     <= 1'b0;
      miso_q      <= 1'b0;
      spi_addr_q  <= '0;
      spi_wdata_q <= '0;
      wr_strobe_q <= 1'b0;
      rd_strobe_q <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hdr_q       <= hdr_d;
      rw_q        <= rw_d;
      sin_q       <= sin_d;
      sout_q      <= sout_d;
      first_q     <= first_d;
      miso_q      <= miso_d;
      spi_addr_q  <= spi_addr_d;
      spi_wdata_q <= spi_wdata_d;
      wr_strobe_q <= wr_strobe_d;
      rd_strobe_q <= rd_strobe_d;
      abort_q     <= abort_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hdr_d       = hdr_q;
    rw_d        = rw_q;
    sin_d       = sin_q;
    sout_d      = sout_q;
    first_d     = first_q;
    miso_d      = miso_q;
    spi_addr_d  = spi_addr_q;
    spi_wdata_d = spi_wdata_q;
    wr_strobe_d = 1'b0;
    rd_strobe_d = 1'b0;
    abort_d     = 1'b0;
    commit      = 1'b0;
    hdr_next    = {hdr_q[HDR_W-2:0], mosi_s};
    sin_next    = {sin_q[DATA_W-2:0], mosi_s};

    unique case (state_q)
      IDLE: begin
        miso_d = 1'b0;
        if (!cs_n_s) begin
          state_d = HEADER;
          cnt_d   = '0;
        end
      end
      HEADER: begin
        if (cs_n_s) begin
          abort_d = 1'b1;
          miso_d  = 1'b0;
          state_d = IDLE;
        end else if (sclk_rise) begin
          hdr_d = hdr_next;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            spi_addr_d = hdr_next[ADDR_W-1:0];
            rw_d       = hdr_next[HDR_RW_BIT];
            first_d    = 1'b1;
            state_d    = DATA;
            if (hdr_next[HDR_RW_BIT]) begin
              rd_strobe_d = 1'b1;
              sout_d      = regs_q[hdr_next[ADDR_W-1:0]];
            end
          end
        end
      end
      DATA: begin
        if (cs_n_s) begin
          abort_d = 1'b1;
          miso_d  = 1'b0;
          state_d = IDLE;
        end else begin
          if (sclk_rise) begin
            cnt_d = cnt_q + 1'b1;
            if (!rw_q) sin_d = sin_next;
            if (cnt_q == CNT_LAST) begin
              state_d = DONE;
              if (!rw_q) begin
                commit      = 1'b1;
                spi_wdata_d = sin_next;
                wr_strobe_d = 1'b1;
              end
            end
          end
          // First fall after the header presents bit 7; later falls shift.
          if (sclk_fall && rw_q) begin
            if (first_q) begin
              miso_d  = sout_q[DATA_W-1];
              first_d = 1'b0;
            end else begin
              miso_d = sout_q[DATA_W-2];
              sout_d = {sout_q[DATA_W-2:0], 1'b0};
            end
          end
        end
      end
      DONE: begin
        if (cs_n_s) begin
          miso_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Register file: SPI commit overrides a same-address local write.
  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      loc_rdata_q <= '0;
      coll_q      <= 1'b0;
    end else begin
      coll_q <= commit && bus.loc_we && (bus.loc_addr == spi_addr_q);
      if (bus.loc_we && !(commit && (bus.loc_addr == spi_addr_q))) begin
        regs_q[bus.loc_addr] <= bus.loc_wdata;
      end
      if (commit) regs_q[spi_addr_q] <= sin_next;
      loc_rdata_q <= regs_q[bus.loc_addr];
    end
  end

  assign bus.miso          = miso_q;
  assign bus.loc_rdata     = loc_rdata_q;
  assign bus.wr_strobe     = wr_strobe_q;
  assign bus.rd_strobe     = rd_strobe_q;
  assign bus.spi_addr      = spi_addr_q;
  assign bus.spi_wdata     = spi_wdata_q;
  assign bus.abort         = abort_q;
  assign bus.loc_collision = coll_q;

endmodule

// File: doc/spi_reg_slave.md
# spi_reg_slave

SPI register-bank responder: a system-clocked SPI slave that oversamples `sclk`/`cs_n`/`mosi` on `mclk` and serves an internal register file. It decodes the 8-bit header (bit 7 = rd_wr, bits 6:0 = address) and then writes or returns one 8-bit data byte, both MSB-first. It sits on the peripheral side of the SPI link and gives local logic a parallel port into the same registers.

## Interface
- `ADDR_W`, 7, address width; register file has 2**ADDR_W entries.
- `DATA_W`, 8, register and data-phase width.
- `mclk` input 1: system clock, the only clock.
- `reset` input 1: asynchronous, active-low reset.
- `sclk` input 1: SPI clock, asynchronous to `mclk`, idle low (mode 0).
- `cs_n` input 1: active-low chip select.
- `mosi` input 1: serial data from the master.
- `miso` output 1: serial data to the master.
- `loc_we` input 1: local write enable.
- `loc_addr` input ADDR_W: local address.
- `loc_wdata` input DATA_W: local write data.
- `loc_rdata` output DATA_W: registered local read data.
- `wr_strobe` output 1: one-cycle pulse on SPI write commit.
- `rd_strobe` output 1: one-cycle pulse on SPI read header accept.
- `spi_addr` output ADDR_W: address of the current or last SPI transaction.
- `spi_wdata` output DATA_W: data committed by the last SPI write.
- `abort` output 1: one-cycle pulse when `cs_n` rises mid-transaction.
- `loc_collision` output 1: one-cycle pulse when a local write is dropped.

## Operation
- Pins `sclk`, `cs_n`, `mosi` pass through 2-flop synchronizers. Edge detect on synchronized `sclk` gives `sclk_rise` and `sclk_fall`.
- Slave samples `mosi` on `sclk_rise` and updates `miso` on `sclk_fall`.
- Bit counter runs 0..7 within each phase.
- **IDLE**: `miso`=0. Synchronized `cs_n` low -> HEADER with counter 0.
- **HEADER**: shift `mosi` into the header on each `sclk_rise`.
  - On the 8th rise, latch `spi_addr`.
  - If rd_wr=1: read the register (registered), load the shift-out register, pulse `rd_strobe`.
  - Go to DATA.
- **DATA, write** (rd_wr=0): shift in 8 bits.
  - On the 8th rise: write the register, update `spi_wdata`, pulse `wr_strobe` -> DONE.
- **DATA, read** (rd_wr=1): `miso` = shift-out bit 7 from the first `sclk_fall` after the header.
  - Shift left on each subsequent fall.
  - After the 8th rise -> DONE.
- **DONE**: ignore further `sclk` edges. `miso` holds the last bit. `cs_n` high -> IDLE, `miso`=0.
- `cs_n` high in HEADER or DATA: pulse `abort`, no register write, go to IDLE, `miso`=0.
- Local port:
  - `loc_rdata` <= reg[`loc_addr`] every cycle.
  - `loc_we` writes reg[`loc_addr`] <= `loc_wdata`.
- Same-cycle SPI commit and `loc_we` to the same address: SPI wins, local write dropped, `loc_collision` pulses. Different addresses: both writes take effect.
- Read-after-write: a local write landing before the read register-fetch cycle is visible to that SPI read.

## Timing
- Reset values: `miso`=0, `loc_rdata`=0, all strobes 0, `spi_addr`=0, `spi_wdata`=0, register file all 0, state IDLE, synchronizers 0 except `cs_n` synchronizer=1.
- Reset asserted mid-transaction: everything returns to reset values immediately; no partial write.
- Pin-to-edge-detect latency: 3 `mclk`.
- `wr_strobe` and the register write occur 1 `mclk` after the detected 8th data rise. The write is visible on `loc_rdata` 1 cycle later.
- `miso` changes 4 `mclk` after the pin `sclk` falling edge.
- Required `sclk` high and low times: each ≥ 4 `mclk` periods.
- Required `cs_n` high between transactions: ≥ 3 `mclk`.

## Structure
- `spi_pkg` holds: `state_t` enum (IDLE, HEADER, DATA, DONE), `HDR_RW_BIT`=7, default `ADDR_W`/`DATA_W` constants.
- Sub-module `spi_sync_edge`: 2-flop synchronizer plus rise/fall detect, parameterized reset value. Instantiated once each for `sclk`, `cs_n`, `mosi` (edge outputs unused for the latter two).

## Test plan
- SPI write header 0x12, data 0xA5 -> `wr_strobe` pulses once with `spi_addr`=0x12, `spi_wdata`=0xA5; `loc_addr`=0x12 returns `loc_rdata`=0xA5.
- Local write 0x3C to 0x05, then SPI read header 0x85 -> `rd_strobe` pulses; `miso` bits 0,0,1,1,1,1,0,0.
- `cs_n` raised after 12 bits of a write to 0x20 -> `abort` pulses, reg[0x20] unchanged (0), `miso`=0.
- Same-cycle `loc_we` (0x07, 0x11) and SPI commit (0x07, 0x99) -> reg[0x07]=0x99, `loc_collision` pulses.
- Reset asserted during DATA phase of a write -> no `wr_strobe`, all outputs 0. A following write of 0x55 to 0x01 succeeds.
- Back-to-back write 0x7F/0xFF then read 0xFF with 3-cycle `cs_n` gap, 20 extra `sclk` in DONE -> `miso` returns 0xFF, extra clocks have no effect.
